// File: rtl/mcdf_arb_sched.sv
// mcdf_arb_sched: three-channel arbiter feeding the MCDF formatter.
// A decision is made in IDLE when the formatter asks for an id and at least
// one channel requests; the lowest prio value wins. The grant is issued as
// one-cycle registered pulses (a2f_val, a2s_ackN) in GRANT. The FSM then
// holds in BUSY until the formatter reports the packet done.
// Optional build macro: MCDF_ARB_RR_EN -- equal-priority ties are resolved
// round-robin from a pointer instead of by lowest channel index.
module mcdf_arb_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       slv0_req,
  input  logic       slv1_req,
  input  logic       slv2_req,
  input  logic [1:0] slv0_prio,
  input  logic [1:0] slv1_prio,
  input  logic [1:0] slv2_prio,
  input  logic       f2a_id_req,
  input  logic       f2a_done,
  output logic       a2s_ack0,
  output logic       a2s_ack1,
  output logic       a2s_ack2,
  output logic       a2f_val,
  output logic [1:0] a2f_id,
  output logic       arb_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t     state_q;
  logic [2:0] ack_q;
  logic       val_q;
  logic [1:0] id_q;

  logic [2:0] req;
  logic [1:0] prio [0:2];

  logic       win_valid;
  logic [1:0] win_id;
  logic [1:0] best_prio;
  logic [1:0] idx;

`ifdef MCDF_ARB_RR_EN
  logic [1:0] ptr_q;
  logic [2:0] rr_sum;
`endif

  assign req     = {slv2_req, slv1_req, slv0_req};
  assign prio[0] = slv0_prio;
  assign prio[1] = slv1_prio;
  assign prio[2] = slv2_prio;

  // Winner search: visit channels in tie-break order; a strictly lower prio
  // replaces the current best, so the first visited channel keeps a tie.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    best_prio = '1;
    idx       = '0;
`ifdef MCDF_ARB_RR_EN
    rr_sum    = '0;
`endif
    for (int unsigned k = 0; k < 3; k++) begin
`ifdef MCDF_ARB_RR_EN
      rr_sum = {1'b0, ptr_q} + 3'(k);
      idx    = (rr_sum >= 3'd3) ? 2'(rr_sum - 3'd3) : rr_sum[1:0];
`else
      idx    = 2'(k);
`endif
      if (req[idx] && (!win_valid || (prio[idx] < best_prio))) begin
        win_valid = 1'b1;
        win_id    = idx;
        best_prio = prio[idx];
      end
    end
  end

  // Arbitration FSM with registered grant outputs; id holds between grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ack_q   <= '0;
      val_q   <= 1'b0;
      id_q    <= '0;
`ifdef MCDF_ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      ack_q <= '0;
      val_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (f2a_id_req && win_valid) begin
            state_q <= S_GRANT;
            ack_q   <= 3'b001 << win_id;
            val_q   <= 1'b1;
            id_q    <= win_id;
`ifdef MCDF_ARB_RR_EN
            ptr_q   <= (win_id == 2'd2) ? 2'd0 : win_id + 2'd1;
`endif
          end
        end
        S_GRANT: begin
          state_q <= f2a_done ? S_IDLE : S_BUSY;
        end
        S_BUSY: begin
          if (f2a_done) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign a2s_ack0 = ack_q[0];
  assign a2s_ack1 = ack_q[1];
  assign a2s_ack2 = ack_q[2];
  assign a2f_val  = val_q;
  assign a2f_id   = id_q;
  assign arb_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_mcdf_arb_sched.sv
// tb_mcdf_arb_sched: directed test of mcdf_arb_sched with hand-computed
// expectations; tie-break expectations follow MCDF_ARB_RR_EN.
module tb_mcdf_arb_sched;

  logic       clk;
  logic       rst;
  logic       slv0_req, slv1_req, slv2_req;
  logic [1:0] slv0_prio, slv1_prio, slv2_prio;
  logic       f2a_id_req;
  logic       f2a_done;
  logic       a2s_ack0, a2s_ack1, a2s_ack2;
  logic       a2f_val;
  logic [1:0] a2f_id;
  logic       arb_busy;

  int unsigned n_tests;
  int unsigned n_fail;

  mcdf_arb_sched dut (
    .clk        (clk),
    .rst        (rst),
    .slv0_req   (slv0_req),
    .slv1_req   (slv1_req),
    .slv2_req   (slv2_req),
    .slv0_prio  (slv0_prio),
    .slv1_prio  (slv1_prio),
    .slv2_prio  (slv2_prio),
    .f2a_id_req (f2a_id_req),
    .f2a_done   (f2a_done),
    .a2s_ack0   (a2s_ack0),
    .a2s_ack1   (a2s_ack1),
    .a2s_ack2   (a2s_ack2),
    .a2f_val    (a2f_val),
    .a2f_id     (a2f_id),
    .arb_busy   (arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] r, input logic [1:0] p0,
                         input logic [1:0] p1, input logic [1:0] p2);
    {slv2_req, slv1_req, slv0_req} = r;
    slv0_prio = p0;
    slv1_prio = p1;
    slv2_prio = p2;
  endtask

  task automatic chk_grant(input string tag, input logic [1:0] id);
    chk({tag, "_val"}, 32'(a2f_val), 32'd1);
    chk({tag, "_id"}, 32'(a2f_id), 32'(id));
    chk({tag, "_ack"}, 32'({a2s_ack2, a2s_ack1, a2s_ack0}), 32'(3'b001 << id));
    chk({tag, "_busy"}, 32'(arb_busy), 32'd1);
  endtask

  task automatic chk_quiet(input string tag, input logic busy_exp);
    chk({tag, "_val"}, 32'(a2f_val), 32'd0);
    chk({tag, "_ack"}, 32'({a2s_ack2, a2s_ack1, a2s_ack0}), 32'd0);
    chk({tag, "_busy"}, 32'(arb_busy), 32'(busy_exp));
  endtask

  // Finish an outstanding packet: drop id_req, pulse done, return to IDLE.
  task automatic finish_pkt();
    f2a_id_req = 1'b0;
    f2a_done   = 1'b1;
    step();
    f2a_done   = 1'b0;
  endtask

  logic [1:0] rr_exp [0:3];

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    f2a_id_req = 1'b0;
    f2a_done   = 1'b0;
    set_req(3'b000, 2'd0, 2'd0, 2'd0);
`ifdef MCDF_ARB_RR_EN
    rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd2; rr_exp[3] = 2'd0;
`else
    rr_exp[0] = 2'd0; rr_exp[1] = 2'd0; rr_exp[2] = 2'd0; rr_exp[3] = 2'd0;
`endif

    // Reset state, with requests pending to show reset dominates.
    set_req(3'b111, 2'd0, 2'd0, 2'd0);
    f2a_id_req = 1'b1;
    step();
    step();
    chk_quiet("rst", 1'b0);
    chk("rst_id", 32'(a2f_id), 32'd0);

    // Priority pick: prio {2,0,1} -> ch1; decision in first cycle out of reset.
    set_req(3'b111, 2'd2, 2'd0, 2'd1);
    rst = 1'b0;
    step();
    chk_grant("prio_g", 2'd1);
    f2a_id_req = 1'b0;
    set_req(3'b000, 2'd0, 2'd0, 2'd0);
    step();
    chk_quiet("prio_busy1", 1'b1);
    step();
    chk_quiet("prio_busy2", 1'b1);
    chk("prio_idhold", 32'(a2f_id), 32'd1);
    finish_pkt();
    chk_quiet("prio_done", 1'b0);
    step();
    chk_quiet("prio_idle", 1'b0);
    chk("prio_idkeep", 32'(a2f_id), 32'd1);

    // Equal-priority sequence from a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(3'b111, 2'd0, 2'd0, 2'd0);
      f2a_id_req = 1'b1;
      step();
      chk_grant($sformatf("tie%0d", i), rr_exp[i]);
      f2a_id_req = 1'b0;
      step();
      finish_pkt();
    end

    // Late request in BUSY is ignored; id_req in BUSY is ignored.
    set_req(3'b001, 2'd1, 2'd0, 2'd0);
    f2a_id_req = 1'b1;
    step();
    chk_grant("late_g0", 2'd0);
    f2a_id_req = 1'b0;
    step();
    set_req(3'b101, 2'd1, 2'd0, 2'd0);
    f2a_id_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_quiet($sformatf("late_busy%0d", i), 1'b1);
    end
    f2a_done = 1'b1;
    step();
    f2a_done = 1'b0;
    chk_quiet("late_idle", 1'b0);
    step();
    chk_grant("late_g2", 2'd2);
    step();
    finish_pkt();

    // Done in the GRANT cycle: IDLE at N+2, new grant at N+3.
    set_req(3'b010, 2'd3, 2'd3, 2'd3);
    f2a_id_req = 1'b1;
    step();
    chk_grant("fast_g1", 2'd1);
    f2a_id_req = 1'b0;
    f2a_done   = 1'b1;
    step();
    f2a_done   = 1'b0;
    chk_quiet("fast_idle", 1'b0);
    set_req(3'b001, 2'd3, 2'd0, 2'd0);
    f2a_id_req = 1'b1;
    step();
    chk_grant("fast_g0", 2'd0);
    step();
    finish_pkt();

    // Reset during GRANT aborts and clears the pointer.
    // Pointer is 1 here under round-robin (last winner ch0).
    set_req(3'b111, 2'd2, 2'd2, 2'd2);
    f2a_id_req = 1'b1;
    step();
`ifdef MCDF_ARB_RR_EN
    chk_grant("abort_g", 2'd1);
`else
    chk_grant("abort_g", 2'd0);
`endif
    rst = 1'b1;
    step();
    chk_quiet("abort_rst", 1'b0);
    rst = 1'b0;
    step();
    chk_grant("abort_after", 2'd0);
    step();
    finish_pkt();

    // id_req with no requests for 10 cycles: nothing happens.
    set_req(3'b000, 2'd0, 2'd0, 2'd0);
    f2a_id_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_quiet($sformatf("noreq%0d", i), 1'b0);
      chk($sformatf("noreq%0d_id", i), 32'(a2f_id), 32'd0);
    end
    f2a_id_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mcdf_arb_sched.md
MCDF_ARB_SCHED -- requirements
Module: mcdf_arb_sched

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL: slv0_req, slv1_req, slv2_req  input  1 each  channel n has a packet ready for the formatter.
REQ-004 SHALL: slv0_prio, slv1_prio, slv2_prio  input  2 each  channel n priority; 0 is highest, 3 is lowest.
REQ-005 SHALL: f2a_id_req  input  1  formatter is ready to accept the next channel id.
REQ-006 SHALL: f2a_done  input  1  single-cycle pulse; formatter has finished the current packet.
REQ-007 SHALL: a2s_ack0, a2s_ack1, a2s_ack2  output  1 each  one-cycle grant pulse to channel n.
REQ-008 SHALL: a2f_val  output  1  one-cycle pulse; a2f_id is valid.
REQ-009 SHALL: a2f_id  output  2  winning channel id, 0..2; value 3 is never driven.
REQ-010 SHALL: arb_busy  output  1  high in GRANT and BUSY states.

Function
REQ-011 SHALL: FSM states are IDLE, GRANT and BUSY.
REQ-012 SHALL: IDLE -> GRANT when f2a_id_req=1 and at least one slvN_req=1; otherwise remain in IDLE.
REQ-013 SHALL: the winner is computed combinationally in the IDLE decision cycle N, using req and prio values sampled in cycle N, and is registered.
REQ-014 SHALL: in GRANT (cycle N+1), a2f_val=1, a2f_id=winner and a2s_ackW=1, each for exactly one cycle; all other acks are 0.
REQ-015 SHALL: GRANT -> BUSY unconditionally, except that f2a_done=1 during GRANT moves directly to IDLE.
REQ-016 SHALL: BUSY -> IDLE on the cycle f2a_done=1; the next decision can occur in the cycle after IDLE is entered.
REQ-017 SHALL: among requesting channels, the lowest prio value wins.
REQ-018 SHALL: equal-priority ties are resolved per REQ-025/REQ-026.
REQ-019 SHALL: changes to req/prio after the decision cycle are ignored until the FSM returns to IDLE.
REQ-020 SHALL: f2a_done received while in IDLE is ignored; f2a_id_req received outside IDLE is ignored.
REQ-021 SHALL: a2f_val, a2s_ack* and a2f_id are registered outputs; a2f_id holds the last winner between grants.

Reset
REQ-022 SHALL: while rst=1, FSM=IDLE, all a2s_ack*=0, a2f_val=0, a2f_id=0, arb_busy=0, and the RR pointer=0.
REQ-023 SHALL: rst asserted during GRANT or BUSY aborts the operation; no ack or val is issued in the cycle after reset.
REQ-024 SHALL: the first decision is possible in the first cycle with rst=0.

Configuration
REQ-025 SHALL: with MCDF_ARB_RR_EN defined, ties are round-robin; a 2-bit pointer is set to (winner+1) mod 3 on each grant, and among tied channels the first at or after the pointer (ascending, wrapping 2->0) wins.
REQ-026 SHALL: without MCDF_ARB_RR_EN, ties go to the lowest channel index, the pointer logic is absent, and behaviour is fully fixed-priority.

Verification
REQ-027 SHALL: req={1,1,1}, prio={2,0,1}, f2a_id_req=1 in cycle N -> in cycle N+1, a2f_val=1, a2f_id=1, a2s_ack1=1 for one cycle; arb_busy=1 until f2a_done.
REQ-028 SHALL: with MCDF_ARB_RR_EN, all req=1 and all prio=0, with f2a_done after each grant -> grants are 0,1,2,0; without the macro -> grants are 0,0,0,0.
REQ-029 SHALL: in BUSY, raise slv2_req with prio 0 and pulse f2a_id_req -> no ack is issued until f2a_done, then ch2 is granted on the next decision.
REQ-030 SHALL: f2a_done=1 in the GRANT cycle -> FSM is in IDLE at N+2; a new request with f2a_id_req in N+2 yields a grant in N+3.
REQ-031 SHALL: rst=1 in the GRANT cycle -> the next cycle has a2f_val=0, all acks=0, arb_busy=0, and the RR pointer=0 (all-equal tie then grants ch0).
REQ-032 SHALL: f2a_id_req=1 with no req for 10 cycles -> FSM stays in IDLE and all outputs stay 0.
